// File: rtl/adder_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_issue_pkg : shared types and wait-class helpers for the issuer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adder_issue_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLASS_1 = 3'd1,
    CLASS_2 = 3'd2,
    CLASS_3 = 3'd3,
    CLASS_4 = 3'd4
  } wait_class_t;

  typedef struct packed {
    logic              cout;
    logic [DATA_W-1:0] sum;
    logic [3:0]        cycles;
  } fifo_entry_t;

  // Long propagate runs across the block boundaries stretch the carry chain.
  function automatic wait_class_t classify(input logic [DATA_W-1:0] p);
    logic [2:0] sel;
    sel = {~(p[12] & p[11]), ~(p[8] & p[7]), ~(p[4] & p[3])};
    case (sel)
      3'b000:         return CLASS_4;
      3'b001, 3'b100: return CLASS_3;
      3'b111:         return CLASS_1;
      default:        return CLASS_2;
    endcase
  endfunction

  function automatic logic [3:0] wait_cycles(input int max_wait, input wait_class_t cls);
    int v;
    v = (max_wait * int'(cls)) / 4;
    if (v < 1) v = 1;
    return v[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_issue_ctrl_if : operand, adder and result handshake bundle     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface adder_issue_ctrl_if;
  import adder_issue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_cin;

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              add_f;
  logic              add_request;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout;
  logic [3:0]        out_cycles;

  // Environment side: operand source, dynamic adder and result sink.
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, add_f, add_request,
           out_valid, out_sum, out_cout, out_cycles
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, add_f, add_request,
           out_valid, out_sum, out_cout, out_cycles
  );
endinterface
`default_nettype wire

// File: rtl/adder_issue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_issue_fifo : 2-entry result FIFO, head always in slot 0        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder_issue_fifo #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  logic [1:0] r_count;
  T           r_mem0;
  T           r_mem1;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= push_data;
          else                 r_mem1 <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= push_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign head  = r_mem0;

endmodule
`default_nettype wire

// File: rtl/adder_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_issue_ctrl : issues operands to a dynamic adder, waits a       |
// | data-dependent time, queues results. Option: ADDER_ISSUE_STATS_EN    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder_issue_ctrl
  import adder_issue_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_issue_ctrl_if.slave  bus
`ifdef ADDER_ISSUE_STATS_EN
  ,
  output logic [15:0]        stat_ops,
  output logic [15:0]        stat_saved
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_cin;
  logic [3:0]        r_n;
  logic [3:0]        r_cnt;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_add_f;
  logic              w_add_request;
  fifo_entry_t       w_push_data;
  fifo_entry_t       w_head;

  // rst_n gate keeps in_ready low for the whole reset window.
  assign bus.in_ready = rst_n && (r_state == ST_IDLE) && !w_full;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    w_next        = r_state;
    w_add_f       = 1'b0;
    w_add_request = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_add_f = 1'b1;
        if (w_accept) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_add_f = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == r_n) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_add_request = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counter runs through LAUNCH so that WAIT lasts exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_n     <= 4'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_cin <= bus.in_cin;
        r_n   <= wait_cycles(MAX_WAIT, classify(bus.in_a ^ bus.in_b));
        r_cnt <= 4'd0;
      end else if ((r_state == ST_LAUNCH) || (r_state == ST_WAIT)) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (r_state == ST_CAPTURE) begin
        r_cnt <= 4'd0;
      end
    end
  end

  assign bus.add_a       = r_a;
  assign bus.add_b       = r_b;
  assign bus.add_cin     = r_cin;
  assign bus.add_f       = w_add_f;
  assign bus.add_request = w_add_request;

  assign w_push      = (r_state == ST_CAPTURE);
  assign w_pop       = bus.out_valid && bus.out_ready;
  assign w_push_data = '{cout: bus.add_cout, sum: bus.add_sum, cycles: r_n};

  adder_issue_fifo #(
    .T (fifo_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign bus.out_valid  = !w_empty;
  assign bus.out_sum    = w_head.sum;
  assign bus.out_cout   = w_head.cout;
  assign bus.out_cycles = w_head.cycles;

`ifdef ADDER_ISSUE_STATS_EN
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_saved;
  logic [16:0] w_ops_inc;
  logic [16:0] w_saved_inc;

  assign w_ops_inc   = {1'b0, r_stat_ops} + 17'd1;
  assign w_saved_inc = {1'b0, r_stat_saved} + {13'd0, MAX_WAIT_L - r_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops   <= 16'd0;
      r_stat_saved <= 16'd0;
    end else if (r_state == ST_CAPTURE) begin
      r_stat_ops   <= w_ops_inc[16]   ? 16'hFFFF : w_ops_inc[15:0];
      r_stat_saved <= w_saved_inc[16] ? 16'hFFFF : w_saved_inc[15:0];
    end
  end

  assign stat_ops   = r_stat_ops;
  assign stat_saved = r_stat_saved;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder_issue_ctrl : scoreboard bench with directed vectors         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adder_issue_ctrl;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  cycles;
    int          exp_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t m_e;

  adder_issue_ctrl_if bus ();

`ifdef ADDER_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_saved;
`endif

  adder_issue_ctrl #(
    .MAX_WAIT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADDER_ISSUE_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_saved (stat_saved)
`endif
  );

  // Ideal adder: result is ready long before add_request.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got sum 0x%0h, expected no result", bus.out_sum);
      end else begin
        m_e = sb.pop_front();
        check("out_sum", 32'(bus.out_sum), 32'(m_e.sum));
        check("out_cout", 32'(bus.out_cout), 32'(m_e.cout));
        check("out_cycles", 32'(bus.out_cycles), 32'(m_e.cycles));
        if (m_e.exp_at >= 0) check("out_valid_cycle", 32'(cyc), 32'(m_e.exp_at));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic ec, input logic [3:0] en,
                       input bit push_exp, input bit lat);
    int   waited;
    exp_t e;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
      bus.in_valid = 1'b0;
    end else begin
      e.sum    = es;
      e.cout   = ec;
      e.cycles = en;
      e.exp_at = lat ? (cyc + 3 + int'(en)) : -1;
      if (push_exp) sb.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_add_f", 32'(bus.add_f), 32'd1);
    check("rst_add_request", 32'(bus.add_request), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);
    check("rst_add_cin", 32'(bus.add_cin), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_cout", 32'(bus.out_cout), 32'd0);
    check("rst_out_cycles", 32'(bus.out_cycles), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd2, 1'b1, 1'b1);
    drain();
    issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd8, 1'b1, 1'b1);
    drain();
`ifdef ADDER_ISSUE_STATS_EN
    check("stat_ops", 32'(stat_ops), 32'd2);
    check("stat_saved", 32'(stat_saved), 32'd6);
`endif
    issue(16'h0018, 16'h0000, 1'b0, 16'h0018, 1'b0, 4'd4, 1'b1, 1'b1);
    drain();
    issue(16'h1980, 16'h0000, 1'b1, 16'h1981, 1'b0, 4'd6, 1'b1, 1'b1);
    drain();
    issue(16'h0100, 16'h0098, 1'b0, 16'h0198, 1'b0, 4'd6, 1'b1, 1'b1);
    drain();
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'd2, 1'b1, 1'b1);
    drain();
    issue(16'h1818, 16'h0001, 1'b0, 16'h1819, 1'b0, 4'd4, 1'b1, 1'b1);
    drain();

    // Back-pressure: two results fill the FIFO, the third waits for a pop.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 4'd2, 1'b1, 1'b0);
    issue(16'h0018, 16'h0000, 1'b0, 16'h0018, 1'b0, 4'd4, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_head_sum", 32'(bus.out_sum), 32'h0003);
    check("full_head_cycles", 32'(bus.out_cycles), 32'd2);
    fork
      issue(16'h1980, 16'h0000, 1'b1, 16'h1981, 1'b0, 4'd6, 1'b1, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_blocks_accept", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while an operation waits: FIFO content and in-flight op are lost.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 4'd2, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 4'd8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_add_f", 32'(bus.add_f), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_add_f", 32'(bus.add_f), 32'd1);
    check("midrst_add_request", 32'(bus.add_request), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_add_a", 32'(bus.add_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(16'h0018, 16'h0005, 1'b0, 16'h001D, 1'b0, 4'd4, 1'b1, 1'b1);
    drain();
    repeat (20) @(negedge clk);
    check("final_pending", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
